mem_access: RTL and testbench



---
 rtl/mem_access.sv | 183 ++++++++++++++++++
 tb/tb_mem_access.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access -- memory-stage access unit.
//
// Sits directly after the EX/MEM register. Takes the ALU result as a byte
// address plus the forwarded store data, issues one request/acknowledge
// transaction on the data-memory port and returns aligned, extended load
// data to writeback. The pipeline is frozen with stall_m while the access
// is in flight.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   valid_m         : a valid instruction is in MEM
//   mem_read_m      : instruction is a load
//   mem_write_m     : instruction is a store (wins when both are set)
//   funct3_m        : access size [1:0] and unsigned-load flag [2]
//   alu_result_m    : byte address
//   write_data_m    : store data
//   dmem_rdata      : memory read word
//   dmem_ack        : one-cycle completion pulse from memory
//   dmem_req        : request valid
//   dmem_we         : request is a write
//   dmem_addr       : word-aligned request address
//   dmem_wdata      : store data replicated across byte lanes
//   dmem_be         : byte enables
//   read_data_m     : formatted load data, nonzero only in the DONE cycle
//   stall_m         : freeze IF/ID/EX/MEM pipeline registers
//   misalign_m      : misaligned-access flag
//
// Configuration
//   MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses are
//                      flagged on misalign_m and issue no request. When not
//                      defined, low address bits below the access size are
//                      ignored and misalign_m is tied low.
//
// Byte-lane logic assumes D_WIDTH = 32.

module mem_access #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_m,
  input  logic               mem_read_m,
  input  logic               mem_write_m,
  input  logic [2:0]         funct3_m,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic [D_WIDTH-1:0] write_data_m,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  input  logic               dmem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [D_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  output logic [3:0]         dmem_be,
  output logic [D_WIDTH-1:0] read_data_m,
  output logic               stall_m,
  output logic               misalign_m
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [D_WIDTH-1:0] r_addr;
  logic [1:0]         r_addrLow;
  logic [D_WIDTH-1:0] r_wdata;
  logic [3:0]         r_be;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [D_WIDTH-1:0] r_rdata;

  logic               w_memOp;
  logic               w_trap;
  logic               w_start;
  logic [3:0]         w_beMask;
  logic [D_WIDTH-1:0] w_wdataRep;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [D_WIDTH-1:0] w_loadData;

  assign w_memOp = valid_m & (mem_read_m | mem_write_m);

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((funct3_m[1:0] == 2'b01) && alu_result_m[0]) ||
                        (funct3_m[1] && (alu_result_m[1:0] != 2'b00));
  assign w_trap = w_memOp & w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  assign w_start = w_memOp & ~w_trap;

  // Lane mask and lane-replicated store data for the incoming instruction.
  // Halfword lanes look only at addr[1], so an odd halfword address lands on
  // the aligned halfword when trapping is disabled.
  always_comb begin
    w_beMask   = 4'b1111;
    w_wdataRep = write_data_m;
    case (funct3_m[1:0])
      2'b00: begin
        w_beMask   = 4'b0001 << alu_result_m[1:0];
        w_wdataRep = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        w_beMask   = alu_result_m[1] ? 4'b1100 : 4'b0011;
        w_wdataRep = {2{write_data_m[15:0]}};
      end
      default: begin
        w_beMask   = 4'b1111;
        w_wdataRep = write_data_m;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the captured memory word and
  // extend it according to the registered funct3.
  always_comb begin
    w_byte     = r_rdata[7:0];
    w_half     = r_rdata[15:0];
    w_loadData = r_rdata;
    case (r_addrLow)
      2'd0: w_byte = r_rdata[7:0];
      2'd1: w_byte = r_rdata[15:8];
      2'd2: w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_addrLow[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000: w_loadData = {{(D_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001: w_loadData = {{(D_WIDTH-16){w_half[15]}}, w_half};
      3'b100: w_loadData = {{(D_WIDTH-8){1'b0}}, w_byte};
      3'b101: w_loadData = {{(D_WIDTH-16){1'b0}}, w_half};
      default: w_loadData = r_rdata;
    endcase
  end

  // Transaction FSM. Request fields are captured once in IDLE so they stay
  // stable for the whole BUSY phase regardless of what the pipeline does.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_addrLow <= 2'b00;
      r_wdata   <= '0;
      r_be      <= 4'b0000;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr    <= {alu_result_m[D_WIDTH-1:2], 2'b00};
            r_addrLow <= alu_result_m[1:0];
            r_wdata   <= w_wdataRep;
            r_be      <= w_beMask;
            r_we      <= mem_write_m;
            r_funct3  <= funct3_m;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_rdata <= dmem_rdata;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req    = (r_state == S_BUSY);
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_be     = r_be;
  assign stall_m     = ((r_state == S_IDLE) & w_start) | (r_state == S_BUSY);
  assign misalign_m  = (r_state == S_IDLE) & w_trap;
  assign read_data_m = ((r_state == S_DONE) && !r_we) ? w_loadData : '0;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- self-checking bench for mem_access.
//
// Directed cases cover the documented scenarios, then randomized loads and
// stores with random ack delays and idle gaps are checked against a
// byte-lane reference model written with plain arithmetic. Define
// MISALIGN_TRAP_EN for both bench and design to exercise the trap build.

module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        valid_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] read_data_m;
  logic        stall_m;
  logic        misalign_m;

  int testsRun;
  int testsFailed;

  mem_access #(.D_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_m      (valid_m),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .read_data_m  (read_data_m),
    .stall_m      (stall_m),
    .misalign_m   (misalign_m)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: number of bytes touched by the access size.
  function automatic int unsigned sizeBytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Lowest byte lane used: the address rounded down to the access size.
  function automatic int unsigned laneOffset(input logic [31:0] a,
                                             input logic [2:0] f3);
    int unsigned n;
    n = sizeBytes(f3);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] modelBe(input logic [31:0] a,
                                         input logic [2:0] f3);
    int unsigned n;
    int unsigned mask;
    n    = sizeBytes(f3);
    mask = ((1 << n) - 1) << laneOffset(a, f3);
    return mask[3:0];
  endfunction

  // Byte lane i of the bus carries store byte (i mod size).
  function automatic logic [31:0] modelWdata(input logic [31:0] wd,
                                             input logic [2:0] f3);
    int unsigned n;
    logic [31:0] res;
    n   = sizeBytes(f3);
    res = 32'd0;
    for (int i = 0; i < 4; i++)
      res = res | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return res;
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] mem);
    longint unsigned span;
    longint unsigned raw;
    int unsigned     n;
    n = sizeBytes(f3);
    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
      span = 64'd1 << (8 * n);
      raw  = ({32'd0, mem} >> (8 * laneOffset(a, f3))) % span;
      if (!f3[2] && raw >= span / 2) raw = raw - span;
      return raw[31:0];
    end
    return mem;
  endfunction

  function automatic bit modelMisaligned(input logic [31:0] a,
                                         input logic [2:0] f3);
    return (a % sizeBytes(f3)) != 0;
  endfunction

  // One cycle with no memory op; optionally fires a stray ack that must
  // not start or complete anything.
  task automatic idleCycle(input bit strayAck);
    @(negedge clk);
    valid_m     = 1'b0;
    mem_read_m  = $urandom_range(0, 1);
    mem_write_m = $urandom_range(0, 1);
    dmem_ack    = strayAck;
    dmem_rdata  = $urandom;
    #1;
    checkOutput("idleStall", 32'(stall_m), 32'd0);
    checkOutput("idleReq", 32'(dmem_req), 32'd0);
    checkOutput("idleRead", read_data_m, 32'd0);
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("idleAfterAckReq", 32'(dmem_req), 32'd0);
    checkOutput("idleAfterAckRead", read_data_m, 32'd0);
  endtask

  // Runs one memory instruction through MEM: present it, answer the request
  // after waitN extra cycles and check bus fields, stall length and result.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] memWord, input int waitN);
    int          reqCycles;
    int          stallCycles;
    logic [31:0] expRead;
    expRead = wr ? 32'd0 : modelRead(f3, addr, memWord);

    @(negedge clk);
    valid_m      = 1'b1;
    mem_read_m   = rd;
    mem_write_m  = wr;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    dmem_ack     = 1'b0;
    dmem_rdata   = $urandom;
    #1;

`ifdef MISALIGN_TRAP_EN
    if (modelMisaligned(addr, f3)) begin
      checkOutput("trapFlag", 32'(misalign_m), 32'd1);
      checkOutput("trapStall", 32'(stall_m), 32'd0);
      checkOutput("trapReq", 32'(dmem_req), 32'd0);
      checkOutput("trapRead", read_data_m, 32'd0);
      @(negedge clk);
      valid_m = 1'b0;
      checkOutput("trapNoReqNext", 32'(dmem_req), 32'd0);
      return;
    end
`endif

    checkOutput("issueMisalign", 32'(misalign_m), 32'd0);
    checkOutput("issueStall", 32'(stall_m), 32'd1);
    checkOutput("issueReq", 32'(dmem_req), 32'd0);
    reqCycles   = 0;
    stallCycles = 1;

    for (int k = 0; k <= waitN; k++) begin
      @(negedge clk);
      if (dmem_req) reqCycles++;
      if (stall_m) stallCycles++;
      checkOutput("busyReq", 32'(dmem_req), 32'd1);
      checkOutput("busyAddr", dmem_addr, addr & 32'hFFFF_FFFC);
      checkOutput("busyBe", 32'(dmem_be), 32'(modelBe(addr, f3)));
      checkOutput("busyWe", 32'(dmem_we), 32'(wr));
      if (wr) checkOutput("busyWdata", dmem_wdata, modelWdata(wd, f3));
      // Upstream keeps moving while frozen; none of it may leak in.
      alu_result_m = $urandom;
      write_data_m = $urandom;
      funct3_m     = 3'($urandom);
      mem_write_m  = $urandom_range(0, 1);
      dmem_ack     = (k == waitN);
      dmem_rdata   = (k == waitN) ? memWord : $urandom;
    end

    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    if (stall_m) stallCycles++;
    checkOutput("doneStall", 32'(stall_m), 32'd0);
    checkOutput("doneReq", 32'(dmem_req), 32'd0);
    checkOutput("doneRead", read_data_m, expRead);
    checkOutput("stallCycles", 32'(stallCycles), 32'(waitN + 2));
    checkOutput("reqCycles", 32'(reqCycles), 32'(waitN + 1));
  endtask

  // Hard time limit so a wedged design still produces a verdict.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b1;
    valid_m      = 1'b0;
    mem_read_m   = 1'b0;
    mem_write_m  = 1'b0;
    funct3_m     = 3'b000;
    alu_result_m = 32'd0;
    write_data_m = 32'd0;
    dmem_rdata   = 32'd0;
    dmem_ack     = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rstReq", 32'(dmem_req), 32'd0);
    checkOutput("rstWe", 32'(dmem_we), 32'd0);
    checkOutput("rstAddr", dmem_addr, 32'd0);
    checkOutput("rstWdata", dmem_wdata, 32'd0);
    checkOutput("rstBe", 32'(dmem_be), 32'd0);
    checkOutput("rstRead", read_data_m, 32'd0);
    checkOutput("rstStall", 32'(stall_m), 32'd0);
    checkOutput("rstMisalign", 32'(misalign_m), 32'd0);
    rst = 1'b0;

    // Documented scenarios.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 3);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'd0, 32'h1280_3456, 1);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h0000_0102, 32'd0, 32'h1280_3456, 0);
    idleCycle(1'b1);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'd0, 32'h8001_0000, 2);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0006, 32'd0, 32'hCAFE_F00D, 1);
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'd0, 0);
    applyStimulus(1'b0, 1'b1, 3'b101, 32'h0000_0042, 32'd0, 32'h9876_5432, 0);

    // Reset while the request is outstanding.
    @(negedge clk);
    valid_m      = 1'b1;
    mem_read_m   = 1'b1;
    mem_write_m  = 1'b0;
    funct3_m     = 3'b010;
    alu_result_m = 32'h0000_0200;
    @(negedge clk);
    checkOutput("preRstReq", 32'(dmem_req), 32'd1);
    valid_m = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstReq", 32'(dmem_req), 32'd0);
    checkOutput("midRstStall", 32'(stall_m), 32'd0);
    checkOutput("midRstRead", read_data_m, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'd0, 32'h0BAD_C0DE, 2);

    // Randomized traffic, including back-to-back ops and stray acks.
    for (int t = 0; t < 60; t++) begin
      int          kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom);
      a    = $urandom;
      applyStimulus(kind != 0, kind != 1, f3, a, $urandom, $urandom,
                    $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idleCycle($urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
